// File: rtl/register_access_arbiter.sv
// register_access_arbiter: round-robin arbiter sharing one register manager among four terminals.
// Define ARB_TIMEOUT_EN to enable the per-phase timeout counter and FAIL reporting.
module register_access_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  term_req,
  input  logic [11:0] term_token,
  input  logic [31:0] term_time,
  input  logic        mgr_P_enable,
  input  logic        mgr_Q_enable,
  output logic        mgr_request,
  output logic        mgr_confirm,
  output logic [2:0]  mgr_user_token,
  output logic [7:0]  mgr_time_data,
  output logic [3:0]  grant,
  output logic [3:0]  term_done,
  output logic [3:0]  term_fail,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, AUTH, WRITE, DONE, FAIL} state_t;
  state_t state, state_nx;
  logic [1:0] idx, idx_nx, rr_ptr, rr_nx, pick;
  logic [2:0] tok, tok_nx;
  logic [7:0] tim, tim_nx;
  logic       to, act, act_now;
  always_comb begin
    pick = rr_ptr;
    for (int k = 3; k >= 0; k--)
      if (term_req[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
  end
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    rr_nx = rr_ptr;
    case (state)
      IDLE: if (|term_req) begin
        state_nx = AUTH;
        idx_nx = pick;
      end
      AUTH, WRITE: if (!term_req[idx]) begin
        state_nx = IDLE;
        rr_nx = idx + 2'd1;
      end else if (state == AUTH ? mgr_P_enable : mgr_Q_enable)
        state_nx = state == AUTH ? WRITE : DONE;
      else if (to)
        state_nx = FAIL;
      default: begin
        state_nx = IDLE;
        rr_nx = idx + 2'd1;
      end
    endcase
  end
  assign tok_nx = state == IDLE ? term_token[int'(pick) * 3 +: 3] : tok;
  assign tim_nx = state == IDLE ? term_time[int'(pick) * 8 +: 8] : tim;
  assign act = state_nx == AUTH || state_nx == WRITE;
  assign act_now = state == AUTH || state == WRITE;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      rr_ptr <= '0;
      tok <= '0;
      tim <= '0;
      grant <= '0;
      busy <= 1'b0;
      mgr_request <= 1'b0;
      mgr_confirm <= 1'b0;
      mgr_user_token <= '0;
      mgr_time_data <= '0;
      term_done <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      rr_ptr <= rr_nx;
      tok <= tok_nx;
      tim <= tim_nx;
      grant <= state_nx == IDLE ? 4'b0 : 4'b1 << idx_nx;
      busy <= state_nx != IDLE;
      mgr_request <= act;
      mgr_confirm <= act;
      mgr_user_token <= act ? tok_nx : 3'b0;
      mgr_time_data <= state_nx == WRITE ? tim_nx : 8'b0;
      term_done <= state_nx == DONE ? 4'b1 << idx_nx : 4'b0;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign to = cnt == 8'(TIMEOUT - 1);
  // Counter restarts whenever the state changes, i.e. on every phase entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      term_fail <= '0;
    end else begin
      cnt <= (state_nx != state || !act_now) ? 8'd0 : cnt + 8'd1;
      term_fail <= state_nx == FAIL ? 4'b1 << idx_nx : 4'b0;
    end
  end
`else
  assign to = 1'b0;
  assign term_fail = '0;
`endif
endmodule

// File: tb/tb_register_access_arbiter.sv
// tb_register_access_arbiter: directed self-checking bench for register_access_arbiter.
module tb_register_access_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  term_req = '0;
  logic [11:0] term_token = '0;
  logic [31:0] term_time = '0;
  logic        mgr_P_enable = 1'b0;
  logic        mgr_Q_enable = 1'b0;
  logic        mgr_request, mgr_confirm, busy;
  logic [2:0]  mgr_user_token;
  logic [7:0]  mgr_time_data;
  logic [3:0]  grant, term_done, term_fail;
  int tests = 0;
  int fails = 0;

  register_access_arbiter #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .term_req(term_req), .term_token(term_token),
    .term_time(term_time), .mgr_P_enable(mgr_P_enable), .mgr_Q_enable(mgr_Q_enable),
    .mgr_request(mgr_request), .mgr_confirm(mgr_confirm), .mgr_user_token(mgr_user_token),
    .mgr_time_data(mgr_time_data), .grant(grant), .term_done(term_done),
    .term_fail(term_fail), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction from IDLE with requests held: P then Q on consecutive cycles.
  task automatic txn(input logic [3:0] g, input logic [2:0] tk, input logic [7:0] tm);
    tick();
    check("rr_grant", 32'(grant), 32'(g));
    check("rr_token", 32'(mgr_user_token), 32'(tk));
    mgr_P_enable = 1'b1;
    tick();
    mgr_P_enable = 1'b0;
    check("rr_time", 32'(mgr_time_data), 32'(tm));
    mgr_Q_enable = 1'b1;
    tick();
    mgr_Q_enable = 1'b0;
    check("rr_done", 32'(term_done), 32'(g));
    tick();
    check("rr_idle_grant", 32'(grant), 32'h0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req", 32'(mgr_request), 32'h0);
    check("rst_done_fail", 32'({term_done, term_fail}), 32'h0);
    @(negedge clock) reset = 1'b1;
    // Single terminal with latched token/time
    term_token = 12'o0005;
    term_time = 32'h0000_0072;
    term_req = 4'b0001;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_req_conf", 32'({mgr_request, mgr_confirm}), 32'h3);
    check("t1_token", 32'(mgr_user_token), 32'h5);
    term_token = 12'o0000;
    term_time = 32'h0;
    tick();
    check("t1_token_latched", 32'(mgr_user_token), 32'h5);
    mgr_P_enable = 1'b1;
    tick();
    mgr_P_enable = 1'b0;
    check("t1_time", 32'(mgr_time_data), 32'h72);
    tick();
    check("t1_wait_write", 32'(mgr_request), 32'h1);
    mgr_Q_enable = 1'b1;
    tick();
    mgr_Q_enable = 1'b0;
    check("t1_done", 32'(term_done), 32'h1);
    check("t1_grant_held", 32'(grant), 32'h1);
    check("t1_req_drop", 32'(mgr_request), 32'h0);
    term_req = 4'b0000;
    tick();
    check("t1_done_pulse", 32'(term_done), 32'h0);
    check("t1_grant_clr", 32'(grant), 32'h0);
    check("t1_busy_clr", 32'(busy), 32'h0);
    // Round robin, pointer now at 1
    term_token = {3'd4, 3'd3, 3'd2, 3'd1};
    term_time = 32'hd3c2_b1a0;
    term_req = 4'b1111;
    txn(4'b0010, 3'd2, 8'hb1);
    txn(4'b0100, 3'd3, 8'hc2);
    txn(4'b1000, 3'd4, 8'hd3);
    txn(4'b0001, 3'd1, 8'ha0);
    txn(4'b0010, 3'd2, 8'hb1);
    term_req = 4'b1000;
    txn(4'b1000, 3'd4, 8'hd3);
    term_req = 4'b0100;
    txn(4'b0100, 3'd3, 8'hc2);
    // Abort: terminal 1 drops in WRITE, terminal 2 pending (pointer at 3)
    term_req = 4'b0110;
    tick();
    check("ab_grant", 32'(grant), 32'h2);
    mgr_P_enable = 1'b1;
    tick();
    mgr_P_enable = 1'b0;
    check("ab_write", 32'(mgr_time_data), 32'hb1);
    term_req = 4'b0100;
    tick();
    check("ab_idle_grant", 32'(grant), 32'h0);
    check("ab_idle_req", 32'(mgr_request), 32'h0);
    check("ab_idle_busy", 32'(busy), 32'h0);
    check("ab_no_pulse", 32'({term_done, term_fail}), 32'h0);
    txn(4'b0100, 3'd3, 8'hc2);
    term_req = 4'b0000;
    tick();
`ifdef ARB_TIMEOUT_EN
    // Timeout in AUTH: pointer at 3, so terminal 0 is granted
    term_req = 4'b0001;
    tick();
    check("to_grant", 32'(grant), 32'h1);
    repeat (14) tick();
    check("to_not_yet", 32'(term_fail), 32'h0);
    tick();
    check("to_fail", 32'(term_fail), 32'h1);
    check("to_no_done", 32'(term_done), 32'h0);
    term_req = 4'b0000;
    tick();
    check("to_fail_pulse", 32'(term_fail), 32'h0);
    // Enable on the final timeout cycle wins
    term_req = 4'b0011;
    tick();
    check("race_grant", 32'(grant), 32'h2);
    mgr_P_enable = 1'b1;
    tick();
    mgr_P_enable = 1'b0;
    repeat (14) tick();
    mgr_Q_enable = 1'b1;
    tick();
    mgr_Q_enable = 1'b0;
    check("race_done", 32'(term_done), 32'h2);
    check("race_no_fail", 32'(term_fail), 32'h0);
    term_req = 4'b0000;
    tick();
`endif
    // Asynchronous reset mid-AUTH
    term_req = 4'b0001;
    tick();
    check("rs_pre", 32'(grant), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rs_grant", 32'(grant), 32'h0);
    check("rs_busy_req", 32'({busy, mgr_request, mgr_confirm}), 32'h0);
    check("rs_token", 32'(mgr_user_token), 32'h0);
    term_req = 4'b1100;
    @(negedge clock) reset = 1'b1;
    tick();
    check("rs_regrant", 32'(grant), 32'h4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
